vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 The block SHALL have parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 The block SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 The block SHALL have port clk_25, input, 1 bit, 25 MHz pixel clock, sole clock of the block.
REQ-010 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-011 The block SHALL have port h_counter_value, input, 16 bits, horizontal position from the horizontal counter.
REQ-012 The block SHALL have port v_counter_value, input, 16 bits, vertical position from the vertical counter.
REQ-013 The block SHALL have port hsync, output, 1 bit, horizontal sync, active low.
REQ-014 The block SHALL have port vsync, output, 1 bit, vertical sync, active low.
REQ-015 The block SHALL have port video_on, output, 1 bit, high inside the visible area.
REQ-016 The block SHALL have port pixel_x, output, 10 bits, visible column.
REQ-017 The block SHALL have port pixel_y, output, 10 bits, visible row.
REQ-018 The block SHALL have port frame_start, output, 1 bit, one-clock pulse at the first pixel of a frame.
REQ-019 The block SHALL have port frame_count, output, 8 bits, count of completed frame starts.
REQ-020 The block SHALL have port range_err, output, 1 bit, sticky out-of-range counter flag.

Function
REQ-021 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 by default), and V_TOTAL SHALL equal V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525 by default).
REQ-022 All outputs SHALL be registered on the rising edge of clk_25, with exactly 1 clock of latency from the input counter values.
REQ-023 hsync SHALL be 0 when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default), and 1 otherwise.
REQ-024 vsync SHALL be 0 when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default), and 1 otherwise.
REQ-025 video_on SHALL be 1 only when h < H_VISIBLE and v < V_VISIBLE.
REQ-026 pixel_x and pixel_y SHALL equal h[9:0] and v[9:0] when video_on is 1, and SHALL be 0 otherwise.
REQ-027 frame_start SHALL be 1 for exactly one clock when the sampled h==0 and v==0, and SHALL not re-pulse while both inputs remain at 0 on consecutive clocks (edge detect on the h==0&&v==0 condition).
REQ-028 frame_count SHALL increment in the same cycle frame_start is asserted, and SHALL wrap from 255 to 0.
REQ-029 range_err SHALL set when h >= H_TOTAL or v >= V_TOTAL is sampled, and SHALL stay at 1 until reset.
REQ-030 While an out-of-range value is sampled, hsync and vsync SHALL be 1, video_on SHALL be 0, pixel_x and pixel_y SHALL be 0, and frame_start SHALL be 0.
REQ-031 All comparisons SHALL be performed on the full 16-bit inputs, so that no truncation aliases values of 1024 or above into the visible area.

Reset
REQ-032 Assertion of reset_n low SHALL immediately force hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, frame_start=0, frame_count=0, range_err=0, and clear the frame-start edge-detect history.
REQ-033 After reset_n deasserts, the first frame_start SHALL occur on the first sampled h==0 and v==0, including if the inputs are already at 0 on the first clock.
REQ-034 Reset asserted mid-frame SHALL abort any pulse in progress, with no glitch on the sync outputs beyond the forced values.

Verification
REQ-035 Sweep h 0..799 with v=0: video_on=1 for h 0..639 (1 clock late), hsync=0 for h 656..751 only, pixel_x tracks h then returns to 0.
REQ-036 Full frame of 800x525 clocks: exactly one frame_start, vsync=0 for v 490..491 (1600 clocks), frame_count 0->1.
REQ-037 Run 256 frames: frame_count wraps 255->0, with one frame_start per frame.
REQ-038 Drive h=800, v=0 for one clock: range_err=1 next clock and stays 1, hsync=1, video_on=0; only reset_n low clears it.
REQ-039 Hold h=0, v=0 for 5 clocks: a single frame_start pulse only.
REQ-040 Assert reset_n low at h=700, v=491 (hsync and vsync low): outputs take reset values asynchronously before the next edge.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA sync decoder: turns externally supplied h/v counter values into registered
// sync, visible-area, pixel coordinate and frame-start outputs with one clock of latency.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk_25,
  input  logic        reset_n,
  input  logic [15:0] h_counter_value,
  input  logic [15:0] v_counter_value,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic [7:0]  frame_count,
  output logic        range_err
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Boundaries held at the full input width so values >= 1024 never alias.
  localparam logic [15:0] H_VIS_END  = 16'(H_VISIBLE);
  localparam logic [15:0] H_SYNC_BEG = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] H_SYNC_END = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] H_TOT      = 16'(H_TOTAL);
  localparam logic [15:0] V_VIS_END  = 16'(V_VISIBLE);
  localparam logic [15:0] V_SYNC_BEG = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] V_SYNC_END = 16'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [15:0] V_TOT      = 16'(V_TOTAL);

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       range_err_q, range_err_d;
  logic       origin_q, origin_d;
  logic       out_of_range;
  logic       at_origin;

  // Decode the sampled counters; out-of-range input forces everything idle.
  always_comb begin
    out_of_range  = (h_counter_value >= H_TOT) || (v_counter_value >= V_TOT);
    at_origin     = (h_counter_value == 16'd0) && (v_counter_value == 16'd0);
    hsync_d       = 1'b1;
    vsync_d       = 1'b1;
    video_on_d    = 1'b0;
    pixel_x_d     = 10'd0;
    pixel_y_d     = 10'd0;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    range_err_d   = range_err_q | out_of_range;
    origin_d      = at_origin;
    if (!out_of_range) begin
      hsync_d    = !((h_counter_value >= H_SYNC_BEG) && (h_counter_value < H_SYNC_END));
      vsync_d    = !((v_counter_value >= V_SYNC_BEG) && (v_counter_value < V_SYNC_END));
      video_on_d = (h_counter_value < H_VIS_END) && (v_counter_value < V_VIS_END);
      if (video_on_d) begin
        pixel_x_d = h_counter_value[9:0];
        pixel_y_d = v_counter_value[9:0];
      end
      // Rising edge of the origin condition, so a held origin pulses once.
      frame_start_d = at_origin && !origin_q;
    end
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      pixel_x_q     <= 10'd0;
      pixel_y_q     <= 10'd0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
      range_err_q   <= 1'b0;
      origin_q      <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      range_err_q   <= range_err_d;
      origin_q      <= origin_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign range_err   = range_err_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: behavioural reference model compared every
// cycle, plus directed literal checks on boundaries, frame counting and reset.
module tb_vga_sync_gen;

  localparam int H_VIS = 640, H_FP = 16, H_SW = 96, H_BP = 48;
  localparam int V_VIS = 480, V_FP = 10, V_SW = 2, V_BP = 33;
  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  logic        clk_25 = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] h_in = 16'd0;
  logic [15:0] v_in = 16'd0;
  logic        hsync, vsync, video_on, frame_start, range_err;
  logic [9:0]  pixel_x, pixel_y;
  logic [7:0]  frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;
  int fs_cnt = 0, vs_low_cnt = 0, wrap_cnt = 0;
  int prev_fc = 0;

  // Reference model state (expected outputs)
  int e_hs = 1, e_vs = 1, e_vid = 0, e_px = 0, e_py = 0, e_fs = 0, e_fc = 0, e_re = 0;
  bit m_prev_origin = 1'b0;

  vga_sync_gen dut (
    .clk_25(clk_25), .reset_n(reset_n),
    .h_counter_value(h_in), .v_counter_value(v_in),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .frame_count(frame_count), .range_err(range_err)
  );

  always #20 clk_25 = ~clk_25;

  // Behavioural model: evaluate the display rules on the integer coordinates.
  always @(posedge clk_25 or negedge reset_n) begin
    int h, v;
    bit oor, origin;
    if (!reset_n) begin
      e_hs = 1; e_vs = 1; e_vid = 0; e_px = 0; e_py = 0; e_fs = 0; e_fc = 0; e_re = 0;
      m_prev_origin = 1'b0;
    end else begin
      h = int'(h_in);
      v = int'(v_in);
      oor = (h >= H_TOT) || (v >= V_TOT);
      origin = (h == 0) && (v == 0);
      if (oor) begin
        e_hs = 1; e_vs = 1; e_vid = 0; e_px = 0; e_py = 0; e_fs = 0;
        e_re = 1;
      end else begin
        e_hs = (h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SW) ? 0 : 1;
        e_vs = (v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SW) ? 0 : 1;
        e_vid = (h < H_VIS && v < V_VIS) ? 1 : 0;
        e_px = e_vid ? h : 0;
        e_py = e_vid ? v : 0;
        e_fs = (origin && !m_prev_origin) ? 1 : 0;
        if (e_fs == 1) e_fc = (e_fc + 1) % 256;
      end
      m_prev_origin = origin;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_25) begin
    if (check_en) begin
      cmp("hsync", int'(hsync), e_hs);
      cmp("vsync", int'(vsync), e_vs);
      cmp("video_on", int'(video_on), e_vid);
      cmp("pixel_x", int'(pixel_x), e_px);
      cmp("pixel_y", int'(pixel_y), e_py);
      cmp("frame_start", int'(frame_start), e_fs);
      cmp("frame_count", int'(frame_count), e_fc);
      cmp("range_err", int'(range_err), e_re);
      if (frame_start) fs_cnt++;
      if (!vsync) vs_low_cnt++;
      if (prev_fc == 255 && frame_count == 8'd0) wrap_cnt++;
      prev_fc = int'(frame_count);
    end
  end

  // Present a coordinate, let it be sampled, return just after the edge.
  task automatic drive(input int h, input int v);
    h_in = 16'(h);
    v_in = 16'(v);
    @(posedge clk_25);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, "_hsync"}, int'(hsync), 1);
    cmp({tag, "_vsync"}, int'(vsync), 1);
    cmp({tag, "_video_on"}, int'(video_on), 0);
    cmp({tag, "_pixel_x"}, int'(pixel_x), 0);
    cmp({tag, "_pixel_y"}, int'(pixel_y), 0);
    cmp({tag, "_frame_start"}, int'(frame_start), 0);
    cmp({tag, "_frame_count"}, int'(frame_count), 0);
    cmp({tag, "_range_err"}, int'(range_err), 0);
  endtask

  task automatic random_phase(input int cycles, input bit allow_oor);
    int sel;
    for (int i = 0; i < cycles; i++) begin
      sel = int'($urandom_range(0, 19));
      if (sel == 0) drive(0, 0);
      else if (sel == 1 && allow_oor) drive(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      else if (sel == 2 && allow_oor) drive(1024 + int'($urandom_range(0, 100)), int'($urandom_range(0, 479)));
      else if (sel == 3) drive(int'($urandom_range(650, 760)), int'($urandom_range(485, 495)));
      else drive(int'($urandom_range(0, H_TOT - 1)), int'($urandom_range(0, V_TOT - 1)));
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk_25);
    #1;
    check_reset_vals("reset");
    check_en = 1'b1;
    reset_n = 1'b1;

    // Origin already present when reset releases: one pulse only over 5 clocks
    fs_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0);
      if (i == 0) begin
        cmp("first_fs", int'(frame_start), 1);
        cmp("first_fc", int'(frame_count), 1);
      end
      if (i == 1) cmp("hold_fs_low", int'(frame_start), 0);
    end
    cmp("hold_fs_count", fs_cnt, 1);

    // Horizontal sweep on line 0
    for (int h = 0; h < H_TOT; h++) begin
      drive(h, 0);
      if (h == 639) begin
        cmp("sweep_vid639", int'(video_on), 1);
        cmp("sweep_px639", int'(pixel_x), 639);
      end
      if (h == 640) begin
        cmp("sweep_vid640", int'(video_on), 0);
        cmp("sweep_px640", int'(pixel_x), 0);
      end
      if (h == 655) cmp("sweep_hs655", int'(hsync), 1);
      if (h == 656) cmp("sweep_hs656", int'(hsync), 0);
      if (h == 751) cmp("sweep_hs751", int'(hsync), 0);
      if (h == 752) cmp("sweep_hs752", int'(hsync), 1);
    end
    drive(123, 45);
    cmp("pix_x_123", int'(pixel_x), 123);
    cmp("pix_y_45", int'(pixel_y), 45);

    // Abbreviated frame: every line, five columns per line
    fs_cnt = 0;
    vs_low_cnt = 0;
    for (int v = 0; v < V_TOT; v++) begin
      drive(0, v);
      drive(639, v);
      drive(640, v);
      drive(700, v);
      drive(799, v);
    end
    cmp("frame_fs_count", fs_cnt, 1);
    cmp("frame_vs_low", vs_low_cnt, 10);
    cmp("frame_fc", int'(frame_count), 2);

    // 256 short frames: counter wraps back to its starting value
    fs_cnt = 0;
    wrap_cnt = 0;
    for (int f = 0; f < 256; f++) begin
      drive(0, 0);
      drive(320, 240);
      drive(799, 524);
    end
    cmp("wrap_fs_count", fs_cnt, 256);
    cmp("wrap_seen", wrap_cnt, 1);
    cmp("wrap_fc", int'(frame_count), 2);

    random_phase(2000, 1'b0);
    cmp("no_range_err", int'(range_err), 0);

    // Out-of-range sample sets the sticky flag
    drive(800, 0);
    cmp("oor_range_err", int'(range_err), 1);
    cmp("oor_hsync", int'(hsync), 1);
    cmp("oor_video_on", int'(video_on), 0);
    drive(10, 10);
    cmp("sticky_range_err", int'(range_err), 1);
    cmp("after_oor_vid", int'(video_on), 1);
    drive(1024 + 5, 5);
    cmp("alias_vid", int'(video_on), 0);
    cmp("alias_px", int'(pixel_x), 0);
    drive(700, 1029);
    cmp("oor_v_hsync", int'(hsync), 1);
    drive(0, 0);
    drive(0, 0);
    drive(0, 0);

    // Asynchronous reset in the middle of both sync pulses
    drive(700, 491);
    cmp("pre_rst_hsync", int'(hsync), 0);
    cmp("pre_rst_vsync", int'(vsync), 0);
    #2 reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    drive(700, 491);
    check_reset_vals("held_rst");
    reset_n = 1'b1;
    drive(700, 491);
    cmp("post_rst_hsync", int'(hsync), 0);

    random_phase(2000, 1'b1);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
